// File: rtl/pll_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pll_ctrl_pkg : shared states and default constants for the PLL lock sequencer
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pll_ctrl_pkg;

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } state_t;

   localparam int DEF_PLL_RST_CYCLES = 16;
   localparam int DEF_LOCK_TIMEOUT   = 65536;
   localparam int DEF_STABLE_CYCLES  = 1024;
   localparam int DEF_MAX_RETRIES    = 4;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff : generic 1-bit two-flop synchronizer with synchronous reset to 0
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
// ----------------------------------------------------------------------------
// pll_lock_sequencer : drives PLL RESETB, qualifies LOCK and gates system reset
// Revision           : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pll_lock_sequencer
   import pll_ctrl_pkg::*;
#(
   parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
   parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
   parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
   parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       locked,
   input  logic       restart,
   output logic       pll_resetb,
   output logic       sys_reset,
   output logic       ready,
   output logic       fail,
   output logic [3:0] retries,
   output logic       lock_lost
);

   localparam int CNT_MAX = max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

   logic             lock_s;
   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic             timeout_hit;

   logic             pll_resetb_next;
   logic             sys_reset_next;
   logic             ready_next;
   logic             fail_next;
   logic [3:0]       retries_next;
   logic             lock_lost_next;

   sync_2ff u_lock_sync (
      .clk   (clk),
      .reset (reset),
      .d     (locked),
      .q     (lock_s)
   );

   assign timeout_hit = (state == WAIT_LOCK) && !lock_s && (cnt == TIMEOUT_LAST);

   // State, counter and all outputs are registered together so every output
   // changes on the same edge as the state it decodes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= RESET_PLL;
         cnt        <= '0;
         pll_resetb <= 1'b0;
         sys_reset  <= 1'b1;
         ready      <= 1'b0;
         fail       <= 1'b0;
         retries    <= 4'd0;
         lock_lost  <= 1'b0;
      end else begin
         state <= state_next;
         if (restart || (state_next != state))
            cnt <= '0;
         else if ((state == RESET_PLL) || (state == WAIT_LOCK) || (state == STABLE))
            cnt <= cnt + CNT_W'(1);
         pll_resetb <= pll_resetb_next;
         sys_reset  <= sys_reset_next;
         ready      <= ready_next;
         fail       <= fail_next;
         retries    <= retries_next;
         lock_lost  <= lock_lost_next;
      end
   end

   always_comb begin
      state_next = state;
      if (restart) begin
         state_next = RESET_PLL;
      end else begin
         unique case (state)
            RESET_PLL: if (cnt == RST_LAST) state_next = WAIT_LOCK;
            WAIT_LOCK: begin
               if (lock_s)
                  state_next = STABLE;
               else if (timeout_hit)
                  state_next = (retries == RETRY_LIMIT) ? FAIL : RESET_PLL;
            end
            STABLE: begin
               if (!lock_s)
                  state_next = WAIT_LOCK;
               else if (cnt == STABLE_LAST)
                  state_next = RUN;
            end
            RUN:     if (!lock_s) state_next = RESET_PLL;
            FAIL:    state_next = FAIL;
            default: state_next = RESET_PLL;
         endcase
      end
   end

   always_comb begin
      pll_resetb_next = !((state_next == RESET_PLL) || (state_next == FAIL));
      sys_reset_next  = (state_next != RUN);
      ready_next      = (state_next == RUN);
      fail_next       = (state_next == FAIL);
      lock_lost_next  = !restart && (state == RUN) && !lock_s;

      retries_next = retries;
      if (restart || (state_next == RUN))
         retries_next = 4'd0;
      else if (timeout_hit && (retries != RETRY_LIMIT))
         retries_next = retries + 4'd1;
   end

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pll_lock_sequencer : scoreboard bench, expected outputs keyed by cycle
// Revision              : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pll_lock_sequencer;

   localparam int N  = 4;
   localparam int TO = 32;
   localparam int S  = 8;
   localparam int MR = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       locked = 1'b0;
   logic       restart = 1'b0;
   logic       pll_resetb, sys_reset, ready, fail, lock_lost;
   logic [3:0] retries;

   always #5 clk = ~clk;

   pll_lock_sequencer #(
      .PLL_RST_CYCLES (N),
      .LOCK_TIMEOUT   (TO),
      .STABLE_CYCLES  (S),
      .MAX_RETRIES    (MR)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .locked     (locked),
      .restart    (restart),
      .pll_resetb (pll_resetb),
      .sys_reset  (sys_reset),
      .ready      (ready),
      .fail       (fail),
      .retries    (retries),
      .lock_lost  (lock_lost)
   );

   // Packed as {ready, sys_reset, pll_resetb, fail, lock_lost, retries[3:0]}
   typedef struct {
      int         cyc;
      logic [8:0] val;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   cyc;
   int   n_checks = 0;
   int   n_pass   = 0;

   function automatic logic [8:0] pk(input logic r, input logic s, input logic p,
                                     input logic f, input logic l, input logic [3:0] n);
      return {r, s, p, f, l, n};
   endfunction

   function automatic logic [8:0] st_rst(input logic [3:0] n);  return pk(0, 1, 0, 0, 0, n); endfunction
   function automatic logic [8:0] st_wait(input logic [3:0] n); return pk(0, 1, 1, 0, 0, n); endfunction
   function automatic logic [8:0] st_fail(input logic [3:0] n); return pk(0, 1, 0, 1, 0, n); endfunction
   function automatic logic [8:0] st_run();  return pk(1, 0, 1, 0, 0, 4'd0); endfunction
   function automatic logic [8:0] st_lost(); return pk(0, 1, 0, 0, 1, 4'd0); endfunction

   function automatic logic [8:0] obs();
      return {ready, sys_reset, pll_resetb, fail, lock_lost, retries};
   endfunction

   task automatic push(input int c, input logic [8:0] v, input string nm);
      exp_t e;
      e.cyc  = c;
      e.val  = v;
      e.name = nm;
      sb.push_back(e);
   endtask

   // Leaves the bench in the drive window of cycle 0 (first cycle after release).
   task automatic do_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      restart = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      cyc = 0;
   endtask

   task automatic test_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      locked = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (obs() !== st_rst(4'd0))
         $display("FAIL reset_values actual=%b required=%b", obs(), st_rst(4'd0));
      else
         n_pass++;
      n_checks++;
      if (dut.lock_s !== 1'b0)
         $display("FAIL reset_sync_cleared actual=%b required=0", dut.lock_s);
      else
         n_pass++;
   endtask

   task automatic test_locked_bringup();
      exp_t e;
      locked = 1'b1;
      do_reset();
      push(0,  st_rst(4'd0),  "bringup_reset_entry");
      push(3,  st_rst(4'd0),  "bringup_resetb_low_last");
      push(4,  st_wait(4'd0), "bringup_resetb_rise");
      push(12, st_wait(4'd0), "bringup_stable_last");
      push(13, st_run(),      "bringup_run_entry");
      push(20, st_run(),      "bringup_run_hold");
      while (cyc <= 20) begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            n_checks++;
            if (obs() !== e.val)
               $display("FAIL %s cyc=%0d actual=%b required=%b", e.name, cyc, obs(), e.val);
            else
               n_pass++;
         end
         @(posedge clk);
         #1 cyc++;
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_checks++;
         $display("FAIL %s never_reached cyc=%0d required=%b", e.name, e.cyc, e.val);
      end
   endtask

   task automatic test_lock_timeout_fail();
      exp_t e;
      logic ready_seen;
      ready_seen = 1'b0;
      locked = 1'b0;
      do_reset();
      push(35,  st_wait(4'd0), "timeout_wait_last");
      push(36,  st_rst(4'd1),  "timeout_retry1");
      push(40,  st_wait(4'd1), "timeout_wait2");
      push(72,  st_rst(4'd2),  "timeout_retry2");
      push(107, st_wait(4'd2), "timeout_wait3_last");
      push(108, st_fail(4'd2), "timeout_fail_entry");
      push(120, st_fail(4'd2), "timeout_fail_hold");
      while (cyc <= 120) begin
         @(negedge clk);
         if (ready === 1'b1) ready_seen = 1'b1;
         while (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            n_checks++;
            if (obs() !== e.val)
               $display("FAIL %s cyc=%0d actual=%b required=%b", e.name, cyc, obs(), e.val);
            else
               n_pass++;
         end
         @(posedge clk);
         #1 cyc++;
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_checks++;
         $display("FAIL %s never_reached cyc=%0d required=%b", e.name, e.cyc, e.val);
      end
      n_checks++;
      if (ready_seen !== 1'b0)
         $display("FAIL timeout_ready_never actual=%b required=0", ready_seen);
      else
         n_pass++;
   endtask

   // Entered directly from the FAIL state left by the previous task.
   task automatic test_restart_in_fail();
      exp_t e;
      int   r;
      r = cyc;
      restart = 1'b1;
      locked  = 1'b1;
      push(r,      st_fail(4'd2), "restart_fail_before");
      push(r + 1,  st_rst(4'd0),  "restart_reset_pll");
      push(r + 4,  st_rst(4'd0),  "restart_resetb_low_last");
      push(r + 5,  st_wait(4'd0), "restart_resetb_rise");
      push(r + 13, st_wait(4'd0), "restart_stable_last");
      push(r + 14, st_run(),      "restart_run_entry");
      while (cyc <= r + 16) begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            n_checks++;
            if (obs() !== e.val)
               $display("FAIL %s cyc=%0d actual=%b required=%b", e.name, cyc, obs(), e.val);
            else
               n_pass++;
         end
         @(posedge clk);
         #1 cyc++;
         if (cyc == r + 1) restart = 1'b0;
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_checks++;
         $display("FAIL %s never_reached cyc=%0d required=%b", e.name, e.cyc, e.val);
      end
   endtask

   task automatic test_stable_abort();
      exp_t e;
      locked = 1'b0;
      do_reset();
      push(12, st_wait(4'd0), "abort_wait_sees_lock");
      push(21, st_wait(4'd0), "abort_no_early_run");
      push(26, st_wait(4'd0), "abort_stable_last");
      push(27, st_run(),      "abort_run_entry");
      push(30, st_run(),      "abort_run_hold");
      while (cyc <= 30) begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            n_checks++;
            if (obs() !== e.val)
               $display("FAIL %s cyc=%0d actual=%b required=%b", e.name, cyc, obs(), e.val);
            else
               n_pass++;
         end
         @(posedge clk);
         #1 cyc++;
         if (cyc == 10) locked = 1'b1;
         if (cyc == 14) locked = 1'b0;
         if (cyc == 16) locked = 1'b1;
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_checks++;
         $display("FAIL %s never_reached cyc=%0d required=%b", e.name, e.cyc, e.val);
      end
   endtask

   // Entered in RUN from the previous task.
   task automatic test_lock_lost();
      exp_t e;
      int   d;
      d = cyc + 1;
      push(d + 2,  st_run(),      "lost_run_until_sync");
      push(d + 3,  st_lost(),     "lost_pulse");
      push(d + 4,  st_rst(4'd0),  "lost_pulse_single");
      push(d + 6,  st_rst(4'd0),  "lost_resetb_low_last");
      push(d + 7,  st_wait(4'd0), "lost_resetb_rise");
      push(d + 15, st_wait(4'd0), "lost_stable_last");
      push(d + 16, st_run(),      "lost_run_return");
      while (cyc <= d + 18) begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            n_checks++;
            if (obs() !== e.val)
               $display("FAIL %s cyc=%0d actual=%b required=%b", e.name, cyc, obs(), e.val);
            else
               n_pass++;
         end
         @(posedge clk);
         #1 cyc++;
         if (cyc == d)     locked = 1'b0;
         if (cyc == d + 4) locked = 1'b1;
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_checks++;
         $display("FAIL %s never_reached cyc=%0d required=%b", e.name, e.cyc, e.val);
      end
   endtask

   task automatic test_reset_mid_stable();
      exp_t e;
      locked = 1'b1;
      do_reset();
      push(7,  st_wait(4'd0), "midrst_stable_before");
      push(9,  st_rst(4'd0),  "midrst_reset_values");
      push(10, st_rst(4'd0),  "midrst_release");
      push(14, st_wait(4'd0), "midrst_resetb_rise");
      push(22, st_wait(4'd0), "midrst_stable_last");
      push(23, st_run(),      "midrst_run_entry");
      while (cyc <= 25) begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            n_checks++;
            if (obs() !== e.val)
               $display("FAIL %s cyc=%0d actual=%b required=%b", e.name, cyc, obs(), e.val);
            else
               n_pass++;
         end
         if (cyc == 9 || cyc == 11) begin
            n_checks++;
            if (dut.lock_s !== 1'b0)
               $display("FAIL midrst_sync_cleared cyc=%0d actual=%b required=0", cyc, dut.lock_s);
            else
               n_pass++;
         end
         if (cyc == 12) begin
            n_checks++;
            if (dut.lock_s !== 1'b1)
               $display("FAIL midrst_sync_relock cyc=%0d actual=%b required=1", cyc, dut.lock_s);
            else
               n_pass++;
         end
         @(posedge clk);
         #1 cyc++;
         if (cyc == 8)  reset = 1'b1;
         if (cyc == 10) reset = 1'b0;
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_checks++;
         $display("FAIL %s never_reached cyc=%0d required=%b", e.name, e.cyc, e.val);
      end
   endtask

   initial begin
      test_reset();
      test_locked_bringup();
      test_lock_timeout_fail();
      test_restart_in_fail();
      test_stable_abort();
      test_lock_lost();
      test_reset_mid_stable();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
